// File: rtl/cnt_pkg.sv
// cnt_pkg: shared types and constants for the cnt_ctrl counter controller.
//   cnt_op_e     command opcodes carried on the command bus
//   cnt_state_e  controller FSM states
//   CNT_WIDTH    default data / argument width
package cnt_pkg;

    localparam int CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_UP   = 2'b10,
        OP_DOWN = 2'b11
    } cnt_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } cnt_state_e;

endpackage

// File: rtl/cnt_ctrl_if.sv
// cnt_ctrl_if: command bus between a command source and cnt_ctrl.
//   cmd_valid  command offered (source -> controller)
//   cmd_ready  controller can accept a command (controller -> source)
//   cmd_op     opcode
//   cmd_arg    LOAD value or UP/DOWN step count
//   abort      terminate an active UP/DOWN run
// Modports: master = command source, slave = cnt_ctrl.
interface cnt_ctrl_if
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
);

    logic             cmd_valid;
    logic             cmd_ready;
    cnt_op_e          cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic             abort;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        output abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        input  abort,
        output cmd_ready
    );

endinterface

// File: rtl/cnt_ctrl.sv
// cnt_ctrl: sequences a downstream up/down counter from a command stream.
// Ports:
//   clk        clock, all logic on its rising edge
//   rst_       synchronous active-low reset
//   bus        command bus (slave side): cmd_valid/cmd_ready/cmd_op/cmd_arg/abort
//   data_in    load value for the downstream counter
//   ld_cnt     downstream load strobe, active-low
//   updn_cnt   downstream count direction, 1 = up
//   count_enb  downstream count enable, active-high
//   busy       a command is in progress
//   done       one-cycle completion pulse
//   aborted    qualifies done: the run was ended by abort
module cnt_ctrl
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
)
(
    input  logic             clk,
    input  logic             rst_,
    cnt_ctrl_if.slave        bus,
    output logic [WIDTH-1:0] data_in,
    output logic             ld_cnt,
    output logic             updn_cnt,
    output logic             count_enb,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    cnt_state_e       state;
    logic [WIDTH-1:0] remaining;

    assign bus.cmd_ready = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);

    // remaining holds the number of enable cycles still owed after the
    // current one, so a run of K steps leaves RUN when it reads zero and
    // the counter never has to wrap. An abort that lands on the final step
    // is indistinguishable from normal completion, so the zero test wins.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state     <= ST_IDLE;
            data_in   <= '0;
            ld_cnt    <= 1'b1;
            updn_cnt  <= 1'b1;
            count_enb <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        case (bus.cmd_op)
                            OP_LOAD: begin
                                data_in <= bus.cmd_arg;
                                ld_cnt  <= 1'b0;
                                state   <= ST_LOAD;
                            end
                            OP_UP, OP_DOWN: begin
                                updn_cnt <= (bus.cmd_op == OP_UP);
                                if (bus.cmd_arg != '0) begin
                                    count_enb <= 1'b1;
                                    remaining <= bus.cmd_arg - WIDTH'(1);
                                    state     <= ST_RUN;
                                end else begin
                                    done  <= 1'b1;
                                    state <= ST_DONE;
                                end
                            end
                            default: begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    ld_cnt <= 1'b1;
                    done   <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_RUN: begin
                    if (remaining == '0) begin
                        count_enb <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else if (bus.abort) begin
                        count_enb <= 1'b0;
                        done      <= 1'b1;
                        aborted   <= 1'b1;
                        remaining <= '0;
                        state     <= ST_DONE;
                    end else begin
                        remaining <= remaining - WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    aborted <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_ctrl.sv
// tb_cnt_ctrl: scoreboard bench for cnt_ctrl with a behavioural model of the
// downstream up/down counter and of the command rules.
module tb_cnt_ctrl;
    import cnt_pkg::*;

    localparam int W = 16;

    typedef struct {
        int         accept_edge;
        int         latency;
        int         loads;
        logic [W-1:0] load_data;
        int         enables;
        logic       dir;
        logic       aborted;
        logic [W-1:0] counter;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_ = 1'b0;
    logic [W-1:0] data_in;
    logic         ld_cnt;
    logic         updn_cnt;
    logic         count_enb;
    logic         busy;
    logic         done;
    logic         aborted;

    cnt_ctrl_if #(.WIDTH(W)) bus ();

    cnt_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .bus       (bus),
        .data_in   (data_in),
        .ld_cnt    (ld_cnt),
        .updn_cnt  (updn_cnt),
        .count_enb (count_enb),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    int edge_count = 0;
    always @(posedge clk) edge_count <= edge_count + 1;

    // downstream up/down counter driven straight from the controller outputs
    logic [W-1:0] counter_q = '0;
    always @(posedge clk) begin
        if (!ld_cnt)
            counter_q <= data_in;
        else if (count_enb)
            counter_q <= updn_cnt ? counter_q + W'(1) : counter_q - W'(1);
    end

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    logic [W-1:0] ref_count = '0;
    logic         ref_dir = 1'b1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: bound expired at edge %0d", name, edge_count);
    endtask

    // Issues one command and keeps abort / held cmd_valid going until done.
    // abort_at: enable cycle (1-based) on which abort is raised, 0 = never.
    // reset_at: enable cycle on which rst_ is pulled low, 0 = never.
    task automatic applyStimulus(input cnt_op_e op, input logic [W-1:0] arg,
                                 input int abort_at, input bit hold_valid, input int reset_at);
        exp_t e;
        int   waited = 0;
        int   steps = 0;
        int   c = 1;
        bit   is_run;
        while (!bus.cmd_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 100) begin
                timeoutFail("ready_wait");
                return;
            end
        end
        is_run = (op == OP_UP || op == OP_DOWN) && arg != '0;
        e.accept_edge = edge_count + 1;
        e.loads = 0;
        e.load_data = '0;
        e.aborted = 1'b0;
        e.latency = 0;
        case (op)
            OP_LOAD: begin
                e.loads = 1;
                e.load_data = arg;
                e.latency = 1;
                ref_count = arg;
            end
            OP_UP, OP_DOWN: begin
                ref_dir = (op == OP_UP);
                if (reset_at > 0)
                    steps = reset_at;
                else if (abort_at > 0 && abort_at < int'(arg)) begin
                    steps = abort_at;
                    e.aborted = 1'b1;
                end else
                    steps = int'(arg);
                e.latency = steps;
                ref_count = ref_dir ? ref_count + W'(steps) : ref_count - W'(steps);
            end
            default: e.latency = 0;
        endcase
        e.enables = steps;
        e.dir = ref_dir;
        e.counter = ref_count;
        if (reset_at == 0)
            exp_q.push_back(e);

        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_arg = arg;
        @(negedge clk);
        if (!hold_valid) bus.cmd_valid = 1'b0;
        while (!done) begin
            if (reset_at > 0 && c == reset_at) begin
                rst_ = 1'b0;
                bus.abort = 1'b0;
                bus.cmd_valid = 1'b0;
                return;
            end
            bus.abort = is_run ? (c == abort_at) : 1'($urandom_range(0, 1));
            if (hold_valid) begin
                bus.cmd_op = cnt_op_e'($urandom_range(0, 3));
                bus.cmd_arg = W'($urandom_range(0, 65535));
            end
            @(negedge clk);
            c++;
            if (c > int'(arg) + 5) begin
                timeoutFail("done_wait");
                break;
            end
        end
        bus.abort = 1'b0;
        bus.cmd_valid = 1'b0;
    endtask

    // monitor: accumulates what the controller drove and compares at done
    int           mon_loads = 0;
    int           mon_enables = 0;
    int           mon_up = 0;
    logic [W-1:0] mon_data = '0;
    exp_t         got;

    always @(negedge clk) begin
        if (!rst_) begin
            mon_loads = 0;
            mon_enables = 0;
            mon_up = 0;
        end else begin
            checkOutput("load_enable_overlap", 64'(!ld_cnt && count_enb), 64'd0);
            if (!done) checkOutput("aborted_outside_done", 64'(aborted), 64'd0);
            if (!ld_cnt) begin
                mon_loads++;
                mon_data = data_in;
            end
            if (count_enb) begin
                mon_enables++;
                if (updn_cnt) mon_up++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    timeoutFail("unexpected_done");
                end else begin
                    got = exp_q.pop_front();
                    checkOutput("latency", 64'(edge_count - got.accept_edge), 64'(got.latency));
                    checkOutput("loads", 64'(mon_loads), 64'(got.loads));
                    if (got.loads > 0) checkOutput("load_data", 64'(mon_data), 64'(got.load_data));
                    checkOutput("enables", 64'(mon_enables), 64'(got.enables));
                    checkOutput("up_enables", 64'(mon_up), got.dir ? 64'(got.enables) : 64'd0);
                    checkOutput("updn_cnt", 64'(updn_cnt), 64'(got.dir));
                    checkOutput("aborted", 64'(aborted), 64'(got.aborted));
                    checkOutput("counter", 64'(counter_q), 64'(got.counter));
                    checkOutput("busy_in_done", 64'(busy), 64'd1);
                end
                mon_loads = 0;
                mon_enables = 0;
                mon_up = 0;
            end
        end
    end

    initial begin
        cnt_op_e      op;
        logic [W-1:0] arg;
        int           ab;
        int           drain = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = OP_NOP;
        bus.cmd_arg = '0;
        bus.abort = 1'b0;

        // reset values, with a command offered that must be ignored
        bus.cmd_valid = 1'b1;
        bus.cmd_op = OP_LOAD;
        bus.cmd_arg = 16'hABCD;
        repeat (3) @(negedge clk);
        checkOutput("rst_ld_cnt", 64'(ld_cnt), 64'd1);
        checkOutput("rst_count_enb", 64'(count_enb), 64'd0);
        checkOutput("rst_updn_cnt", 64'(updn_cnt), 64'd1);
        checkOutput("rst_data_in", 64'(data_in), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_aborted", 64'(aborted), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        bus.cmd_valid = 1'b0;
        rst_ = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 64'(bus.cmd_ready), 64'd1);

        applyStimulus(OP_LOAD, 16'h1234, 0, 1'b0, 0);
        applyStimulus(OP_LOAD, 16'h00FE, 0, 1'b0, 0);
        applyStimulus(OP_UP, 16'd5, 0, 1'b0, 0);
        applyStimulus(OP_LOAD, 16'h0001, 0, 1'b0, 0);
        applyStimulus(OP_DOWN, 16'd3, 0, 1'b0, 0);
        applyStimulus(OP_UP, 16'd10, 4, 1'b0, 0);
        applyStimulus(OP_DOWN, 16'd6, 6, 1'b0, 0);
        applyStimulus(OP_UP, 16'd0, 0, 1'b1, 0);
        applyStimulus(OP_NOP, 16'd7, 0, 1'b1, 0);
        applyStimulus(OP_LOAD, 16'h0000, 0, 1'b1, 0);
        applyStimulus(OP_UP, 16'hFFFF, 0, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            op = cnt_op_e'($urandom_range(0, 3));
            arg = (op == OP_LOAD) ? W'($urandom_range(0, 65535)) : W'($urandom_range(0, 20));
            ab = ($urandom_range(0, 1) == 1 && arg != '0) ? $urandom_range(1, int'(arg)) : 0;
            applyStimulus(op, arg, ab, 1'($urandom_range(0, 1)), 0);
        end

        // reset in the middle of a DOWN 100 run
        applyStimulus(OP_DOWN, 16'd100, 0, 1'b0, 10);
        @(negedge clk);
        checkOutput("midrun_rst_count_enb", 64'(count_enb), 64'd0);
        checkOutput("midrun_rst_busy", 64'(busy), 64'd0);
        checkOutput("midrun_rst_done", 64'(done), 64'd0);
        ref_dir = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = OP_LOAD;
        bus.cmd_arg = 16'h5555;
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", 64'(bus.cmd_ready), 64'd1);
        checkOutput("post_rst_busy", 64'(busy), 64'd0);
        checkOutput("post_rst_ld_cnt", 64'(ld_cnt), 64'd1);
        applyStimulus(OP_UP, 16'd2, 0, 1'b0, 0);

        while (exp_q.size() != 0 && drain < 50) begin
            @(negedge clk);
            drain++;
        end
        if (exp_q.size() != 0) timeoutFail("scoreboard_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cnt_ctrl.md
CNT_CTRL -- requirements
Module: cnt_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: width of counter data and command argument.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst_  input  1  reset, synchronous, active-low.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_op  input  2  opcode: NOP=00, LOAD=01, UP=10, DOWN=11.
REQ-007 cmd_arg  input  WIDTH  LOAD value, or step count for UP/DOWN.
REQ-008 abort  input  1  terminate an active UP/DOWN run.
REQ-009 data_in  output  WIDTH  load value to the downstream up/down counter.
REQ-010 ld_cnt  output  1  counter load strobe, active-low.
REQ-011 updn_cnt  output  1  count direction: 1=up, 0=down.
REQ-012 count_enb  output  1  counter count enable, active-high.
REQ-013 busy  output  1  command in progress.
REQ-014 done  output  1  one-cycle pulse at command completion.
REQ-015 aborted  output  1  qualifies done: the run ended by abort.

Function
REQ-016 States SHALL be IDLE, LOAD, RUN and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-017 Handshake SHALL occur on an edge where cmd_valid=1 and cmd_ready=1; cmd_valid at any other time SHALL be ignored.
REQ-018 ld_cnt, updn_cnt, count_enb, data_in, done and aborted SHALL all be registered outputs.
REQ-019 LOAD accepted at edge N: data_in=cmd_arg and ld_cnt=0 in cycle N+1 only; DONE in cycle N+2.
REQ-020 UP/DOWN with arg K>0 accepted at edge N: count_enb=1 in cycles N+1..N+K exactly; DONE in cycle N+K+1.
REQ-021 updn_cnt SHALL be set at acceptance (UP=1, DOWN=0) and SHALL hold its value until the next UP/DOWN command.
REQ-022 UP/DOWN with arg 0, and NOP: count_enb SHALL stay 0; DONE in cycle N+1.
REQ-023 Internal remaining-step counter, WIDTH bits: loaded with arg-1 at acceptance and decremented each RUN cycle; RUN exits when it reads 0, with no wrap-around.
REQ-024 The maximum arg (2^WIDTH-1) SHALL give exactly 2^WIDTH-1 enable cycles.
REQ-025 abort=1 sampled at a RUN edge: count_enb=0 from the next cycle, then DONE with aborted=1.
REQ-026 abort outside RUN SHALL be ignored.
REQ-027 If abort coincides with the final step, the run SHALL complete normally with aborted=0.
REQ-028 DONE SHALL last exactly one cycle with done=1 and then return to IDLE; aborted is valid only while done=1, otherwise 0.
REQ-029 busy SHALL be 1 in LOAD, RUN and DONE.
REQ-030 ld_cnt=0 and count_enb=1 SHALL never be asserted in the same cycle.

Reset
REQ-031 rst_=0 at an edge SHALL force IDLE regardless of state, including mid-RUN.
REQ-032 Reset values: ld_cnt=1, count_enb=0, updn_cnt=1, data_in=0, done=0, aborted=0, busy=0, remaining count=0.
REQ-033 A command presented during reset SHALL NOT be accepted.
REQ-034 cmd_ready SHALL be 1 in the first cycle after rst_ returns to 1.

Structure
REQ-035 Shared package cnt_pkg SHALL hold the opcode enum (cnt_op_e), the state enum (cnt_state_e) and the WIDTH default constant.
REQ-036 The block SHALL be a single module with no sub-module; the FSM and the step counter are both local to cnt_ctrl.
REQ-037 The block's outputs SHALL connect directly, port-for-port, to the downstream up/down counter.

Verification
REQ-038 Reset then LOAD 16'h1234 -> ld_cnt=0 for one cycle with data_in=16'h1234; done one cycle later; counter output reads 16'h1234.
REQ-039 UP 5 after loading 16'h00FE -> count_enb high exactly 5 cycles, updn_cnt=1; counter output reads 16'h0103; done=1, aborted=0.
REQ-040 DOWN 3 after loading 16'h0001 -> counter output wraps to 16'hFFFE; done on cycle N+4.
REQ-041 UP 10 with abort on the 4th enable cycle -> exactly 4 enables, done=1 with aborted=1; counter advanced by 4.
REQ-042 UP 0 and NOP -> no enable and no load; done in cycle N+1; cmd_valid held during busy is not accepted.
REQ-043 rst_=0 mid-RUN of DOWN 100 -> count_enb=0 and state IDLE after the edge; cmd_ready=1 in the first cycle after rst_ returns to 1.
